// File: rtl/uart_cmd_controller_pkg.sv
// Shared opcodes, response codes, FSM states and default sizing
// for the UART command sequencer.
package uart_cmd_controller_pkg;

  localparam int NUM_REGS_DEF      = 4;
  localparam int TIMEOUT_TICKS_DEF = 640;
  localparam int TO_W_DEF          = 12;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] OP_ID   = 8'h3F;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] RSP_ID  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_EXEC,
    S_WAIT_TX
  } state_t;

  function automatic logic has_addr(input logic [7:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/uart_cmd_controller_timeout.sv
// Saturating inter-byte timeout counter; expired stays high
// once the limit is reached until cleared.
module uart_cmd_controller_timeout #(
  parameter int TO_W  = 12,
  parameter int LIMIT = 640
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [TO_W-1:0] LIM = TO_W'(LIMIT);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/uart_cmd_controller.sv
// UART command sequencer: parses W/R/? commands from rx bytes,
// drives the config register bank and issues one reply byte.
module uart_cmd_controller
  import uart_cmd_controller_pkg::*;
#(
  parameter int NUM_REGS      = NUM_REGS_DEF,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int TO_W          = TO_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  s_tick,
  input  logic                  rx_done,
  input  logic [7:0]            rx_data,
  input  logic                  tx_done,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic [8*NUM_REGS-1:0] cfg_regs,
  output logic                  busy,
  output logic                  err
);

  localparam int         AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREG8 = 8'(NUM_REGS);

  state_t       r_state;
  state_t       w_next;
  logic [7:0]   r_op;
  logic [7:0]   r_addr;
  logic [7:0]   r_data;
  logic [7:0]   r_tx_data;
  logic [7:0]   r_bank [NUM_REGS];
  logic [7:0]   w_reply;
  logic         w_nak;
  logic         w_addr_ok;
  logic         w_wait;
  logic         w_expired;
  logic         w_wr_en;
  logic [AW-1:0] w_idx;

  assign w_idx     = r_addr[AW-1:0];
  assign w_addr_ok = (r_addr < NREG8);
  assign w_wait    = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
  assign w_wr_en   = (r_state == S_EXEC) && (r_op == OP_WR) && w_addr_ok;

  // Held clear outside the operand states, so entry always starts at zero.
  uart_cmd_controller_timeout #(
    .TO_W  (TO_W),
    .LIMIT (TIMEOUT_TICKS)
  ) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .i_clr     (rx_done | ~w_wait),
    .i_en      (s_tick & w_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (rx_done) begin
          w_next = has_addr(rx_data) ? S_GET_ADDR : S_EXEC;
        end
      end
      S_GET_ADDR: begin
        if (rx_done) begin
          w_next = (r_op == OP_WR) ? S_GET_DATA : S_EXEC;
        end else if (w_expired) begin
          w_next = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (rx_done) begin
          w_next = S_EXEC;
        end else if (w_expired) begin
          w_next = S_IDLE;
        end
      end
      S_EXEC:    w_next = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_done) begin
          w_next = S_IDLE;
        end
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_reply = RSP_NAK;
    w_nak   = 1'b1;
    unique case (1'b1)
      (r_op == OP_ID): begin
        w_reply = RSP_ID;
        w_nak   = 1'b0;
      end
      (r_op == OP_WR) && w_addr_ok: begin
        w_reply = RSP_ACK;
        w_nak   = 1'b0;
      end
      (r_op == OP_RD) && w_addr_ok: begin
        w_reply = r_bank[w_idx];
        w_nak   = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    tx_start = (r_state == S_EXEC);
    busy     = (r_state != S_IDLE);
    tx_data  = (r_state == S_EXEC) ? w_reply : r_tx_data;
    err      = 1'b0;
    unique case (r_state)
      S_GET_ADDR, S_GET_DATA: err = w_expired & ~rx_done;
      S_EXEC:                 err = w_nak | rx_done;
      S_WAIT_TX:              err = rx_done;
      default:                err = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op      <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_tx_data <= '0;
    end else begin
      if ((r_state == S_IDLE) && rx_done) r_op <= rx_data;
      if ((r_state == S_GET_ADDR) && rx_done) r_addr <= rx_data;
      if ((r_state == S_GET_DATA) && rx_done) r_data <= rx_data;
      if (r_state == S_EXEC) r_tx_data <= w_reply;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= '0;
    end else if (w_wr_en) begin
      r_bank[w_idx] <= r_data;
    end
  end

  always_comb begin
    cfg_regs = '0;
    for (int i = 0; i < NUM_REGS; i++) cfg_regs[8*i +: 8] = r_bank[i];
  end

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Bench for uart_cmd_controller: command-level reference model
// checked every cycle, plus directed literal checks.
module tb_uart_cmd_controller;

  localparam int LIM = 640;

  logic        clock   = 1'b0;
  logic        reset   = 1'b0;
  logic        s_tick  = 1'b0;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_done = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] cfg_regs;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  uart_cmd_controller dut (
    .clock    (clock),
    .reset    (reset),
    .s_tick   (s_tick),
    .rx_done  (rx_done),
    .rx_data  (rx_data),
    .tx_done  (tx_done),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .cfg_regs (cfg_regs),
    .busy     (busy),
    .err      (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Command-level model: bytes of the pending command, reply in flight,
  // operand-gap tick count and the register bank contents.
  logic [7:0] m_cmd[$];
  logic [7:0] m_bank[4] = '{default: 8'h00};
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_wa = 8'h00;
  logic [7:0] m_wd = 8'h00;
  bit         m_fresh = 0;
  bit         m_tx = 0;
  bit         m_nak = 0;
  bit         m_wr = 0;
  int         m_ticks = 0;

  function automatic int need(input logic [7:0] op);
    if (op == 8'h57) return 3;
    if (op == 8'h52) return 2;
    return 1;
  endfunction

  always @(posedge clock or negedge reset) begin
    logic [7:0] op;
    logic [7:0] a;
    if (!reset) begin
      m_cmd.delete();
      foreach (m_bank[i]) m_bank[i] = 8'h00;
      m_last = 8'h00;
      m_fresh = 0;
      m_tx = 0;
      m_nak = 0;
      m_wr = 0;
      m_ticks = 0;
    end else if (m_fresh) begin
      if (m_wr) m_bank[m_wa[1:0]] = m_wd;
      m_fresh = 0;
      m_wr = 0;
    end else if (m_tx) begin
      if (tx_done) m_tx = 0;
    end else if (m_cmd.size() != 0 && m_ticks >= LIM && !rx_done) begin
      m_cmd.delete();
      m_ticks = 0;
    end else if (rx_done) begin
      m_cmd.push_back(rx_data);
      m_ticks = 0;
      op = m_cmd[0];
      if (m_cmd.size() == need(op)) begin
        a = (m_cmd.size() > 1) ? m_cmd[1] : 8'h00;
        m_nak = 1;
        m_last = 8'h15;
        if (op == 8'h3F) begin
          m_last = 8'hA5;
          m_nak = 0;
        end else if ((op == 8'h57 || op == 8'h52) && a < 8'd4) begin
          m_nak = 0;
          if (op == 8'h57) begin
            m_last = 8'h06;
            m_wr = 1;
            m_wa = a;
            m_wd = m_cmd[2];
          end else begin
            m_last = m_bank[a[1:0]];
          end
        end
        m_fresh = 1;
        m_tx = 1;
        m_cmd.delete();
      end
    end else if (m_cmd.size() != 0 && s_tick && m_ticks < LIM) begin
      m_ticks++;
    end
  end

  always @(negedge clock) begin
    logic        e_err;
    logic [31:0] e_cfg;
    e_cfg = {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
    e_err = (m_fresh && m_nak) || (m_tx && rx_done) ||
            (m_cmd.size() != 0 && m_ticks >= LIM && !rx_done);
    chk("m_busy", busy, (m_cmd.size() != 0) || m_tx);
    chk("m_tx_start", tx_start, m_fresh);
    chk("m_tx_data", tx_data, m_last);
    chk("m_err", err, e_err);
    chk("m_cfg", cfg_regs, e_cfg);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic txdone();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      s_tick = 1'b1;
      step();
      s_tick = 1'b0;
      if (i != n - 1) step();
    end
  endtask

  initial begin
    step();
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_cfg", cfg_regs, 32'h0);
    chk("rst_err", err, 0);
    step();
    reset = 1'b1;
    step();

    send(8'h57); send(8'h02); send(8'h3C);
    chk("w_start", tx_start, 1);
    chk("w_ack", tx_data, 8'h06);
    step();
    chk("w_cfg", cfg_regs[23:16], 8'h3C);
    chk("w_start_drop", tx_start, 0);
    idle(3);
    txdone();
    chk("w_idle", busy, 0);

    send(8'h52); send(8'h02);
    chk("r_start", tx_start, 1);
    chk("r_data", tx_data, 8'h3C);
    idle(4);
    chk("r_hold", tx_data, 8'h3C);
    chk("r_busy", busy, 1);
    txdone();
    chk("r_busy_fall", busy, 0);

    send(8'hFF);
    chk("bad_op_nak", tx_data, 8'h15);
    chk("bad_op_err", err, 1);
    step();
    txdone();

    send(8'h52); send(8'h07);
    chk("bad_addr_nak", tx_data, 8'h15);
    chk("bad_addr_err", err, 1);
    step();
    txdone();
    chk("bad_addr_cfg", cfg_regs, 32'h003C_0000);

    send(8'h57); send(8'h01);
    ticks(LIM);
    chk("to_err", err, 1);
    chk("to_no_tx", tx_start, 0);
    step();
    chk("to_idle", busy, 0);
    chk("to_cfg", cfg_regs, 32'h003C_0000);

    send(8'h57); send(8'h01);
    ticks(LIM - 1);
    step();
    chk("to_639_busy", busy, 1);
    chk("to_639_err", err, 0);
    send(8'h5A);
    chk("to_639_ack", tx_data, 8'h06);
    step();
    chk("to_639_cfg", cfg_regs[15:8], 8'h5A);
    txdone();

    send(8'h52); send(8'h00);
    chk("ovr_reply", tx_data, 8'h00);
    step();
    rx_data = 8'h3F;
    rx_done = 1'b1;
    #2;
    chk("ovr_err", err, 1);
    step();
    rx_done = 1'b0;
    chk("ovr_busy", busy, 1);
    chk("ovr_hold", tx_data, 8'h00);
    txdone();
    chk("ovr_done", busy, 0);
    send(8'h3F);
    chk("id_reply", tx_data, 8'hA5);
    step();
    txdone();

    send(8'h57); send(8'h03);
    chk("rd_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("rd_rst_busy", busy, 0);
    chk("rd_rst_data", tx_data, 8'h00);
    chk("rd_rst_cfg", cfg_regs, 32'h0);
    chk("rd_rst_err", err, 0);
    step();
    reset = 1'b1;
    step();
    send(8'h57); send(8'h00); send(8'hAB);
    chk("rd_next_ack", tx_data, 8'h06);
    step();
    chk("rd_next_cfg", cfg_regs[7:0], 8'hAB);
    txdone();

    send(8'h57); send(8'h01); send(8'h11);
    step();
    step();
    chk("rw_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("rw_rst_data", tx_data, 8'h00);
    chk("rw_rst_busy", busy, 0);
    chk("rw_rst_cfg", cfg_regs, 32'h0);
    step();
    reset = 1'b1;
    step();
    send(8'h57); send(8'h03); send(8'h77);
    chk("rw_next_ack", tx_data, 8'h06);
    step();
    chk("rw_next_cfg", cfg_regs, 32'h7700_0000);
    txdone();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
